// File: rtl/i2c_oled_pkg.sv
// Shared definitions for the SSD1306-style I2C responder: FSM state
// encoding, bus address, control bytes, command codes and the status-byte
// helper used by the optional read path.
package i2c_oled_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    ADDR        = 4'd1,
    ADDR_ACK    = 4'd2,
    CTRL        = 4'd3,
    CTRL_ACK    = 4'd4,
    PAYLOAD     = 4'd5,
    PAYLOAD_ACK = 4'd6,
    IGNORE      = 4'd7,
    RD_BYTE     = 4'd8,
    RD_ACK      = 4'd9
  } state_e;

  localparam logic [6:0] OLED_ADDR       = 7'h3C;

  localparam logic [7:0] CTRL_CMD        = 8'h00;
  localparam logic [7:0] CTRL_CMD_SINGLE = 8'h80;
  localparam logic [7:0] CTRL_DATA       = 8'h40;

  localparam logic [7:0] CMD_RESUME_RAM  = 8'hA4;
  localparam logic [7:0] CMD_ENTIRE_ON   = 8'hA5;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;

  // Status byte returned on reads: bit6 flags "display off".
  function automatic logic [7:0] status_byte(input logic disp_on);
    return {1'b0, ~disp_on, 6'b00_0000};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronisers followed by one edge-detect register.
// Produces single-cycle scl_rise/scl_fall and START/STOP pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s_o,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Synchroniser chains and edge-detect register; reset to an idle (high) bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s_o    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s_o    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s_o & ~scl_prev_q;
  assign scl_fall_o = ~scl_s_o & scl_prev_q;
  // SDA edges only count as START/STOP while SCL is stably high.
  assign start_o    = scl_s_o & scl_prev_q & sda_prev_q & ~sda_s_o;
  assign stop_o     = scl_s_o & scl_prev_q & ~sda_prev_q & sda_s_o;

endmodule

// File: rtl/i2c_oled_responder.sv
// Behavioural SSD1306-style I2C target: address match + ACK, control-byte
// decode (Co, D/C#), payload strobes and display on/off tracking.
// Optional macro I2C_OLED_READ_STATUS_EN: ACK reads and return a status byte.
module i2c_oled_responder
  import i2c_oled_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = OLED_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       addr_match,
  output logic       frame_stop,
  output logic       display_on
);

  logic sync_scl_unused, sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(CLK), .rst_i(RST), .scl_i(scl_in), .sda_i(sda_in),
    .scl_s_o(sync_scl_unused), .sda_s_o(sda_s),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall),
    .start_o(start), .stop_o(stop)
  );

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       ack_ph_q, ack_ph_d;
  logic       co_q, co_d, dc_q, dc_d;
  logic       oe_q, oe_d, am_q, am_d, bv_q, bv_d, fs_q, fs_d, don_q, don_d;
  logic [7:0] bdata_q, bdata_d;
  logic       bdc_q, bdc_d;
`ifdef I2C_OLED_READ_STATUS_EN
  logic       rd_q, rd_d;
  logic [7:0] status;
  assign status = status_byte(don_q);
`endif

  logic [7:0] byte_full;
  logic       byte_done;
  assign byte_full = {shreg_q[6:0], sda_s};
  assign byte_done = scl_rise && (bitcnt_q == 3'd7);

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ack_ph_q <= 1'b0;
      co_q     <= 1'b0;
      dc_q     <= 1'b0;
      oe_q     <= 1'b0;
      am_q     <= 1'b0;
      bv_q     <= 1'b0;
      fs_q     <= 1'b0;
      don_q    <= 1'b0;
      bdata_q  <= '0;
      bdc_q    <= 1'b0;
`ifdef I2C_OLED_READ_STATUS_EN
      rd_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ack_ph_q <= ack_ph_d;
      co_q     <= co_d;
      dc_q     <= dc_d;
      oe_q     <= oe_d;
      am_q     <= am_d;
      bv_q     <= bv_d;
      fs_q     <= fs_d;
      don_q    <= don_d;
      bdata_q  <= bdata_d;
      bdc_q    <= bdc_d;
`ifdef I2C_OLED_READ_STATUS_EN
      rd_q     <= rd_d;
`endif
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    ack_ph_d = ack_ph_q;
    co_d     = co_q;
    dc_d     = dc_q;
    oe_d     = oe_q;
    am_d     = am_q;
    bv_d     = 1'b0;
    fs_d     = 1'b0;
    don_d    = don_q;
    bdata_d  = bdata_q;
    bdc_d    = bdc_q;
`ifdef I2C_OLED_READ_STATUS_EN
    rd_d     = rd_q;
`endif
    if (stop) begin
      state_d  = IDLE;
      oe_d     = 1'b0;
      ack_ph_d = 1'b0;
      fs_d     = am_q;
      am_d     = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      ack_ph_d = 1'b0;
      am_d     = 1'b0;
    end else begin
      case (state_q)
        ADDR, CTRL, PAYLOAD: begin
          if (scl_rise) begin
            shreg_d  = byte_full;
            bitcnt_d = bitcnt_q + 3'd1;
          end
          if (byte_done) begin
            state_d = PAYLOAD_ACK;
            if (state_q == ADDR) begin
`ifdef I2C_OLED_READ_STATUS_EN
              rd_d    = byte_full[0];
              state_d = (byte_full[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
`else
              state_d = (byte_full[7:1] == SLAVE_ADDR && !byte_full[0]) ? ADDR_ACK : IGNORE;
`endif
            end else if (state_q == CTRL) begin
              co_d    = byte_full[7];
              dc_d    = byte_full[6];
              state_d = CTRL_ACK;
            end else begin
              bv_d    = 1'b1;
              bdata_d = byte_full;
              bdc_d   = dc_q;
              if (!dc_q && byte_full == CMD_DISPLAY_ON)  don_d = 1'b1;
              if (!dc_q && byte_full == CMD_DISPLAY_OFF) don_d = 1'b0;
            end
          end
        end
        ADDR_ACK, CTRL_ACK, PAYLOAD_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              oe_d     = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              ack_ph_d = 1'b0;
              bitcnt_d = '0;
              case (state_q)
                ADDR_ACK: begin
                  am_d    = 1'b1;
                  state_d = CTRL;
`ifdef I2C_OLED_READ_STATUS_EN
                  if (rd_q) begin
                    state_d = RD_BYTE;
                    shreg_d = status;
                    oe_d    = ~status[7];
                  end
`endif
                end
                CTRL_ACK: state_d = PAYLOAD;
                default:  state_d = co_q ? CTRL : PAYLOAD;
              endcase
            end
          end
        end
`ifdef I2C_OLED_READ_STATUS_EN
        // ack_ph marks "last bit sampled" here and "master ACKed" in RD_ACK.
        RD_BYTE: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) ack_ph_d = 1'b1;
          end
          if (scl_fall) begin
            if (ack_ph_q) begin
              oe_d     = 1'b0;
              ack_ph_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shreg_d = {shreg_q[6:0], 1'b0};
              oe_d    = ~shreg_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) ack_ph_d = 1'b1;
            else        state_d  = IGNORE;
          end
          if (scl_fall && ack_ph_q) begin
            ack_ph_d = 1'b0;
            bitcnt_d = '0;
            shreg_d  = status;
            oe_d     = ~status[7];
            state_d  = RD_BYTE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign sda_oe     = oe_q;
  assign byte_valid = bv_q;
  assign byte_data  = bdata_q;
  assign byte_dc    = bdc_q;
  assign addr_match = am_q;
  assign frame_stop = fs_q;
  assign display_on = don_q;

endmodule

// File: tb/tb_i2c_oled_responder.sv
// Directed bench for i2c_oled_responder: bit-banged I2C master on a
// wired-AND SDA line, strobe/frame-stop monitor, hand-computed expectations.
module tb_i2c_oled_responder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, byte_valid, byte_dc, addr_match, frame_stop, display_on;
  logic [7:0] byte_data;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] strobes[$];
  int         fs_cnt;
  logic       oe_seen;
  int         ack_cnt;
  logic       ack_b, line_b;

  assign sda_line = sda_m & ~sda_oe;

  always #5 CLK = ~CLK;

  i2c_oled_responder dut (
    .CLK(CLK), .RST(RST), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_dc(byte_dc), .addr_match(addr_match), .frame_stop(frame_stop),
    .display_on(display_on)
  );

  always @(negedge CLK) begin
    if (byte_valid) strobes.push_back({byte_dc, byte_data});
    if (frame_stop) fs_cnt = fs_cnt + 1;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] strobe_at(input int i);
    if (i < strobes.size()) return strobes[i];
    return 9'h1FF;
  endfunction

  task automatic qwait();
    repeat (4) @(negedge CLK);
  endtask

  task automatic clock_bit(input logic b, output logic oe_mid, output logic line_mid);
    sda_m = b;
    qwait();
    scl_m = 1'b1;
    qwait();
    oe_mid   = sda_oe;
    line_mid = sda_line;
    qwait();
    scl_m = 1'b0;
    qwait();
  endtask

  task automatic tx(input logic [7:0] d);
    logic a, l;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], a, l);
    clock_bit(1'b1, a, l);
    if (a) ack_cnt++;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    qwait();
  endtask

  task automatic clr_mon();
    strobes.delete();
    fs_cnt  = 0;
    oe_seen = 1'b0;
    ack_cnt = 0;
  endtask

  initial begin
    logic [7:0] rd;
    clr_mon();
    repeat (5) @(negedge CLK);
    check_eq("rst_oe", sda_oe, 0);
    check_eq("rst_outs", {byte_valid, byte_data, byte_dc, addr_match, frame_stop, display_on}, 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Single command AF turns the display on
    clr_mon();
    i2c_start(); tx(8'h78); tx(8'h00); tx(8'hAF);
    check_eq("t1_am", addr_match, 1);
    i2c_stop();
    check_eq("t1_acks", ack_cnt, 3);
    check_eq("t1_nstr", strobes.size(), 1);
    check_eq("t1_str0", strobe_at(0), {1'b0, 8'hAF});
    check_eq("t1_don", display_on, 1);
    check_eq("t1_fs", fs_cnt, 1);
    check_eq("t1_am_after", addr_match, 0);

    // Streaming data bytes
    clr_mon();
    i2c_start(); tx(8'h78); tx(8'h40); tx(8'h11); tx(8'h22); tx(8'h33); i2c_stop();
    check_eq("t2_acks", ack_cnt, 5);
    check_eq("t2_nstr", strobes.size(), 3);
    check_eq("t2_str0", strobe_at(0), {1'b1, 8'h11});
    check_eq("t2_str1", strobe_at(1), {1'b1, 8'h22});
    check_eq("t2_str2", strobe_at(2), {1'b1, 8'h33});

    // Co=1 single command, then a new control byte switching to data
    clr_mon();
    i2c_start(); tx(8'h78); tx(8'h80); tx(8'hAE); tx(8'h40); tx(8'h55); i2c_stop();
    check_eq("t3_nstr", strobes.size(), 2);
    check_eq("t3_str0", strobe_at(0), {1'b0, 8'hAE});
    check_eq("t3_str1", strobe_at(1), {1'b1, 8'h55});
    check_eq("t3_don", display_on, 0);
    check_eq("t3_acks", ack_cnt, 5);

    // Wrong address is ignored entirely
    clr_mon();
    i2c_start(); tx(8'h7A);
    check_eq("t4_am", addr_match, 0);
    tx(8'h00);
    i2c_stop();
    check_eq("t4_oe_seen", oe_seen, 0);
    check_eq("t4_nstr", strobes.size(), 0);
    check_eq("t4_fs", fs_cnt, 0);

    // Repeated START after 4 payload bits drops the partial byte
    clr_mon();
    i2c_start(); tx(8'h78); tx(8'h00);
    clock_bit(1'b1, ack_b, line_b); clock_bit(1'b0, ack_b, line_b);
    clock_bit(1'b1, ack_b, line_b); clock_bit(1'b0, ack_b, line_b);
    i2c_start();
    check_eq("t5_am_rs", addr_match, 0);
    tx(8'h78); tx(8'h00); tx(8'hA5); i2c_stop();
    check_eq("t5_nstr", strobes.size(), 1);
    check_eq("t5_str0", strobe_at(0), {1'b0, 8'hA5});
    check_eq("t5_don", display_on, 0);

    // AF then A4: display stays on
    clr_mon();
    i2c_start(); tx(8'h78); tx(8'h00); tx(8'hAF); tx(8'hA4); i2c_stop();
    check_eq("t6_nstr", strobes.size(), 2);
    check_eq("t6_don", display_on, 1);

    // STOP right after the control byte
    clr_mon();
    i2c_start(); tx(8'h78); tx(8'h00); i2c_stop();
    check_eq("t7_nstr", strobes.size(), 0);
    check_eq("t7_fs", fs_cnt, 1);

    // Read request
    clr_mon();
    i2c_start(); tx(8'h79);
`ifdef I2C_OLED_READ_STATUS_EN
    check_eq("t8_ack", ack_cnt, 1);
    rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, ack_b, line_b);
      rd = {rd[6:0], line_b};
    end
    check_eq("t8_status", rd, 8'h00);
    clock_bit(1'b1, ack_b, line_b);
    qwait();
    check_eq("t8_oe_nack", sda_oe, 0);
`else
    rd = 8'h00;
    check_eq("t8_ack", ack_cnt, 0);
    check_eq("t8_am", addr_match, rd[0]);
`endif
    i2c_stop();

    // Reset in the middle of the address ACK
    clr_mon();
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(8'h78 >> i, ack_b, line_b);
    check_eq("t9_oe_pre", sda_oe, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("t9_oe_rst", sda_oe, 0);
    check_eq("t9_don_rst", display_on, 0);
    RST = 1'b0;
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    check_eq("t9_fs", fs_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
